riscv_data_mem: RTL and testbench
=================================

// Module: riscv_data_mem
// PURPOSE
// - Byte-addressed, little-endian data memory for the core's load/store stage.
// - Adds valid/ready request and response handshakes, byte/half/word access with RISC-V load extension,
//   programmable wait states, and error reporting (misaligned, out-of-range, illegal size).
// - Sits between the LSU and on-chip storage; one transaction outstanding at a time.
// PARAMETERS
// - ADDR_WIDTH   32     request address width
// - DEPTH_BYTES  16384  storage size in bytes; must be a multiple of 4
// - WAIT_STATES  1      extra cycles between accept and access, 0..15
// PORTS
// - clk          in   1           clock; all state updates on rising edge
// - rst          in   1           asynchronous, active-low reset
// - req_valid    in   1           request present
// - req_ready    out  1           block can accept a request
// - req_we       in   1           1 = store, 0 = load
// - req_size     in   2           00 = byte, 01 = half, 10 = word, 11 = illegal
// - req_unsigned in   1           loads only: 1 = zero-extend, 0 = sign-extend
// - req_addr     in   ADDR_WIDTH  byte address
// - req_wdata    in   32          store data; low bytes are used for byte/half
// - resp_valid   out  1           response present
// - resp_ready   in   1           consumer takes response
// - resp_rdata   out  32          load result, already extended; 0 for stores and errors
// - resp_err     out  1           transaction rejected; no memory access performed
// BEHAVIOUR
// - States: IDLE, WAIT, RESP. Reset (rst = 0, async) forces IDLE, req_ready = 1, resp_valid = 0,
//   resp_rdata = 0, resp_err = 0, wait counter = 0. Memory contents are undefined after reset.
// - IDLE: req_ready = 1. Accept on an edge with req_valid && req_ready, latching we/size/unsigned/addr/wdata.
// - Error check at accept. An error is any of:
//   - size 11;
//   - half access with addr[0] = 1;
//   - word access with addr[1:0] != 0;
//   - addr + bytes > DEPTH_BYTES.
//   On error go directly to RESP with err = 1, rdata = 0, and no access, regardless of WAIT_STATES.
// - Legal access:
//   - WAIT_STATES = 0: IDLE -> RESP on the accept edge.
//   - Otherwise: IDLE -> WAIT with counter = WAIT_STATES - 1; decrement each cycle; WAIT -> RESP on the edge
//     where counter = 0.
// - Memory access happens on the edge that enters RESP. This is atomic: all enabled bytes are written on one edge.
// - Stores write bytes addr .. addr+N-1 from wdata[8N-1:0], LSB at the lowest address. resp_rdata = 0, err = 0.
// - Loads assemble bytes little-endian, then extend:
//   - byte uses bit 7 when signed;
//   - half uses bit 15 when signed;
//   - word is unchanged.
//   The result is registered into resp_rdata.
// - Latency: resp_valid first asserts WAIT_STATES+1 cycles after the accept edge (1 cycle for errors).
// - RESP: resp_valid = 1; rdata and err are held stable until resp_valid && resp_ready, then RESP -> IDLE.
//   req_ready = 0 in WAIT and RESP. There is no same-edge RESP-to-accept bypass, so the next accept is
//   possible one cycle after the handshake.
// - req_valid is ignored outside IDLE; a request need not be held once accepted.
// - Reset mid-operation: transaction dropped. A store not yet at its access edge leaves memory unchanged.
// - Address arithmetic is done in ADDR_WIDTH+1 bits so addr near 2^ADDR_WIDTH-1 cannot wrap past the range check.
// TESTING
// - WAIT_STATES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_valid 2 cycles after accept,
//   rdata = 0xDEADBEEF, err = 0.
// - Store byte 0x80 @0x21, then load byte @0x21: signed -> 0xFFFFFF80, unsigned -> 0x00000080.
//   Also byte 0x20 unchanged.
// - Load half @0x13, word @0x22, and size 11 -> each gives err = 1, rdata = 0 after 1 cycle, memory unchanged.
// - Load word @DEPTH_BYTES-4 -> ok; @DEPTH_BYTES-2 -> err. Load half @0xFFFFFFFE -> err (no wrap).
// - Hold resp_ready = 0 for 5 cycles -> resp_valid/rdata/err stable, req_ready = 0, new req_valid ignored.
//   Release -> IDLE next cycle.
// - Assert rst during WAIT of a store -> outputs hit reset values immediately; the target bytes keep their
//   old values on a later load.

Source files
------------

// File: rtl/riscv_data_mem_if.sv
// riscv_data_mem_if: request/response handshake bundle
// between the LSU (master) and the data memory (slave).
interface riscv_data_mem_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: little-endian byte-addressed data memory
// with handshakes, wait states and access error reporting.
module riscv_data_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 16384,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst,
  riscv_data_mem_if.slave bus
);
  localparam int NW  = DEPTH_BYTES / 4;
  localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] DEPTH = AW1'(DEPTH_BYTES);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic accept, access, req_err;

  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;

  logic                  a_we, a_uns;
  logic [1:0]            a_size;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata;

  logic [AW1-1:0] nbytes, end_addr;
  logic [WW-1:0]  widx;
  logic [4:0]     sh;
  logic [3:0]     be;
  logic [31:0]    wlane, rword, rlane, ld_val;
  logic [31:0]    mem [NW];
  logic           unused_addr;

  // Range check is one bit wider so high addresses cannot wrap.
  always_comb begin
    nbytes = AW1'(4);
    unique case (1'b1)
      bus.req_size == 2'b00: nbytes = AW1'(1);
      bus.req_size == 2'b01: nbytes = AW1'(2);
      default:               nbytes = AW1'(4);
    endcase
    end_addr = {1'b0, bus.req_addr} + nbytes;
    req_err  = (bus.req_size == 2'b11)
             | ((bus.req_size == 2'b01) & bus.req_addr[0])
             | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
             | (end_addr > DEPTH);
  end

  // With no wait states the access uses the live request.
  assign a_we    = (state == IDLE) ? bus.req_we       : we_q;
  assign a_uns   = (state == IDLE) ? bus.req_unsigned : uns_q;
  assign a_size  = (state == IDLE) ? bus.req_size     : size_q;
  assign a_addr  = (state == IDLE) ? bus.req_addr     : addr_q;
  assign a_wdata = (state == IDLE) ? bus.req_wdata    : wdata_q;

  assign widx  = a_addr[WW+1:2];
  assign sh    = {a_addr[1:0], 3'b000};
  assign wlane = a_wdata << sh;
  assign rword = mem[widx];
  assign rlane = rword >> sh;
  assign unused_addr = ^{a_addr[ADDR_WIDTH-1:WW+2]};

  always_comb begin
    be     = 4'b1111;
    ld_val = rlane;
    unique case (1'b1)
      a_size == 2'b00: begin
        be     = 4'b0001 << a_addr[1:0];
        ld_val = {{24{~a_uns & rlane[7]}}, rlane[7:0]};
      end
      a_size == 2'b01: begin
        be     = 4'b0011 << a_addr[1:0];
        ld_val = {{16{~a_uns & rlane[15]}}, rlane[15:0]};
      end
      default: begin
        be     = 4'b1111;
        ld_val = rlane;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            state_n = RESP;
          end else if (WS == 4'd0) begin
            state_n = RESP;
            access  = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = WS - 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
          access  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (access) rdata_q <= a_we ? 32'd0 : ld_val;
    end
  end

  // Storage has no reset; a held reset blocks any write.
  always_ff @(posedge clk) begin
    if (rst && access && a_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_riscv_data_mem.sv
// tb_riscv_data_mem: directed vector table, corner sequences
// and random traffic checked against a byte-level model.
module tb_riscv_data_mem;
  localparam int AW    = 32;
  localparam int DEPTH = 16384;
  localparam int WS    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_data_mem_if #(.ADDR_WIDTH(AW)) bus ();

  riscv_data_mem #(
    .ADDR_WIDTH (AW),
    .DEPTH_BYTES(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt[$];
  logic [7:0] ref_mem [int unsigned];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Byte-array reference: errors by rule, loads by byte assembly.
  task automatic model(input logic we, input logic [1:0] sz,
                       input logic un, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output bit known);
    longint unsigned nb, v, a;
    nb = 64'd1 << sz;
    a  = ad;
    rd = 32'd0;
    known = 1'b1;
    er = (sz == 2'd3) || (a % nb != 0) || (a + nb > DEPTH);
    if (!er && we) begin
      for (int i = 0; i < int'(nb); i++)
        ref_mem[ad + i] = wd[8*i +: 8];
    end else if (!er) begin
      v = 0;
      for (int i = 0; i < int'(nb); i++) begin
        if (ref_mem.exists(ad + i))
          v |= longint'(ref_mem[ad + i]) << (8 * i);
        else
          known = 1'b0;
      end
      if (!un && nb < 4 && v[8*nb-1])
        v |= ~((64'd1 << (8 * nb)) - 1);
      rd = v[31:0];
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: no resp_valid, want by %0d", WS + 1);
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] sz,
                     input logic un, input logic [31:0] ad,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output logic er, output int lat);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = ad;
    bus.req_wdata    = wd;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    wait_resp(lat);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata,      32'd0);
    chk({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
  endtask

  logic [31:0] rd, mrd;
  logic        er, mer;
  bit          known;
  int          lat;

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;

    vt.push_back('{1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2});
    vt.push_back('{0, 2, 0, 32'h10, 0, 32'hDEADBEEF, 0, 2});
    vt.push_back('{1, 0, 0, 32'h20, 32'hFFFFFF11, 0, 0, 2});
    vt.push_back('{1, 0, 0, 32'h21, 32'h12345680, 0, 0, 2});
    vt.push_back('{0, 0, 0, 32'h21, 0, 32'hFFFFFF80, 0, 2});
    vt.push_back('{0, 0, 1, 32'h21, 0, 32'h00000080, 0, 2});
    vt.push_back('{0, 0, 1, 32'h20, 0, 32'h00000011, 0, 2});
    vt.push_back('{0, 1, 0, 32'h20, 0, 32'hFFFF8011, 0, 2});
    vt.push_back('{0, 1, 1, 32'h20, 0, 32'h00008011, 0, 2});
    vt.push_back('{0, 1, 0, 32'h13, 0, 0, 1, 1});
    vt.push_back('{0, 2, 0, 32'h22, 0, 0, 1, 1});
    vt.push_back('{0, 3, 0, 32'h10, 0, 0, 1, 1});
    vt.push_back('{1, 3, 0, 32'h10, 32'hFFFFFFFF, 0, 1, 1});
    vt.push_back('{1, 1, 0, 32'h13, 32'h0000FFFF, 0, 1, 1});
    vt.push_back('{0, 2, 0, 32'h10, 0, 32'hDEADBEEF, 0, 2});
    vt.push_back('{1, 2, 0, DEPTH - 4, 32'h12345678, 0, 0, 2});
    vt.push_back('{0, 2, 0, DEPTH - 4, 0, 32'h12345678, 0, 2});
    vt.push_back('{0, 0, 1, DEPTH - 1, 0, 32'h00000012, 0, 2});
    vt.push_back('{0, 2, 0, DEPTH - 2, 0, 0, 1, 1});
    vt.push_back('{0, 1, 0, 32'hFFFFFFFE, 0, 0, 1, 1});
    vt.push_back('{1, 0, 0, DEPTH, 32'h77, 0, 1, 1});
    vt.push_back('{1, 1, 0, 32'h32, 32'hFFFFA5C3, 0, 0, 2});
    vt.push_back('{0, 1, 0, 32'h32, 0, 32'hFFFFA5C3, 0, 2});
    vt.push_back('{0, 0, 0, 32'h33, 0, 32'hFFFFFFA5, 0, 2});
    vt.push_back('{0, 0, 0, 32'h32, 0, 32'hFFFFFFC3, 0, 2});

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("in_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("after_reset");

    foreach (vt[i]) begin
      model(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr,
            vt[i].wdata, mrd, mer, known);
      txn(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr,
          vt[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
    end

    // Backpressure: response held, new requests ignored.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp(lat);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d_valid", c), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("hold%0d_rdata", c), bus.resp_rdata, 32'hDEADBEEF);
      chk($sformatf("hold%0d_err", c), 32'(bus.resp_err), 32'd0);
      chk($sformatf("hold%0d_ready", c), 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("release_valid", 32'(bus.resp_valid), 32'd0);
    chk("release_ready", 32'(bus.req_ready), 32'd1);
    txn(0, 2, 0, 32'h10, 0, rd, er, lat);
    chk("after_hold_rdata", rd, 32'hDEADBEEF);

    // Reset in WAIT of a store: memory keeps old bytes.
    model(1, 2, 0, 32'h40, 32'h01020304, mrd, mer, known);
    txn(1, 2, 0, 32'h40, 32'h01020304, rd, er, lat);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("wait_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outs("rst_wait");
    @(posedge clk); #2;
    rst = 1'b1;
    txn(0, 2, 0, 32'h40, 0, rd, er, lat);
    chk("rst_store_dropped", rd, 32'h01020304);

    // Reset in RESP of a load clears the held data.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp(lat);
    chk("pre_rst_rdata", bus.resp_rdata, 32'hDEADBEEF);
    rst = 1'b0;
    #1;
    check_reset_outs("rst_resp");
    @(posedge clk); #2;
    rst = 1'b1;

    // Prefill the random windows so loads are predictable.
    for (int a = 0; a < 'h80; a += 4) begin
      model(1, 2, 0, a, $urandom, mrd, mer, known);
      txn(1, 2, 0, a, ref_mem[a + 3] << 24 | ref_mem[a + 2] << 16
          | ref_mem[a + 1] << 8 | ref_mem[a], rd, er, lat);
    end
    for (int a = DEPTH - 16; a < DEPTH; a += 4) begin
      model(1, 2, 0, a, $urandom, mrd, mer, known);
      txn(1, 2, 0, a, ref_mem[a + 3] << 24 | ref_mem[a + 2] << 16
          | ref_mem[a + 1] << 8 | ref_mem[a], rd, er, lat);
    end
    txn(0, 2, 0, 32'h7C, 0, rd, er, lat);
    chk("prefill_7c", rd, {ref_mem[32'h7F], ref_mem[32'h7E],
                           ref_mem[32'h7D], ref_mem[32'h7C]});

    for (int n = 0; n < 300; n++) begin
      logic        we, un;
      logic [1:0]  sz;
      logic [31:0] ad, wd;
      int          r;
      we = 1'($urandom);
      un = 1'($urandom);
      wd = $urandom;
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r  = $urandom_range(0, 9);
      if (r < 7)      ad = $urandom_range(0, 'h7F);
      else if (r < 9) ad = DEPTH - 16 + $urandom_range(0, 19);
      else            ad = $urandom;
      model(we, sz, un, ad, wd, mrd, mer, known);
      txn(we, sz, un, ad, wd, rd, er, lat);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(mer));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), mer ? 32'd1 : 32'(WS + 1));
      if (known) chk($sformatf("rnd%0d_rdata", n), rd, mrd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
